sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/arm_mem_pkg.sv | 12 +
 rtl/sram_ctrl.sv | 118 +++++++++++
 tb/tb_sram_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared constants, FSM state type and address helper for the data-memory SRAM controller
package arm_mem_pkg;
  localparam int DATA_MEM_BASE = 1024;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WORD_IDX_W = SRAM_ADDR_W - 1;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} sram_state_t;
  // DATA_MEM_BASE is word aligned, so the word index is the word-address bits minus the base in words
  function automatic logic [WORD_IDX_W-1:0] word_idx(input logic [WORD_IDX_W-1:0] a);
    return a - WORD_IDX_W'(DATA_MEM_BASE / 4);
  endfunction
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: 32-bit load/store over a 16-bit SRAM in two half-accesses; define SRAM_LAST_READ_EN for a one-entry last-read buffer
module sram_ctrl
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_out,
  input  logic [SRAM_DATA_W-1:0] sram_dq_in,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);
  sram_state_t           r_state;
  logic [3:0]            r_cnt;
  logic                  r_wr;
  logic [WORD_IDX_W-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [31:0]           r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [SRAM_DATA_W-1:0] r_dq_out;
  logic                  r_dq_oe;
  logic                  r_we_n;
  logic [WORD_IDX_W-1:0] w_idx;
  logic                  w_req;
  logic                  w_hit;
  logic                  w_start;
  logic                  w_last;
  logic                  w_unused_addr;

  assign w_idx = word_idx(address[18:2]);
  assign w_unused_addr = ^{address[31:19], address[1:0]};
  assign w_req = rd_en | wr_en;
  assign w_start = (r_state == IDLE) && w_req && !w_hit;
  assign w_last = r_cnt == 4'(WAIT_CYCLES - 1);
  assign ready = ((r_state == IDLE) && (!w_req || w_hit)) || (r_state == DONE);
  assign read_data = r_read_data;
  assign sram_addr = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe = r_dq_oe;
  assign sram_we_n = r_we_n;

`ifdef SRAM_LAST_READ_EN
  logic                  r_lr_valid;
  logic [WORD_IDX_W-1:0] r_lr_idx;
  assign w_hit = rd_en && !wr_en && r_lr_valid && (r_lr_idx == w_idx);
  // remember the word of the last completed read; any write invalidates it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lr_valid <= 1'b0;
      r_lr_idx <= '0;
    end else if (w_start && wr_en) begin
      r_lr_valid <= 1'b0;
    end else if (r_state == HIGH && w_last && !r_wr) begin
      r_lr_valid <= 1'b1;
      r_lr_idx <= r_idx;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  // access sequencer: latch request, drive low half then high half, each held WAIT_CYCLES cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_wr <= 1'b0;
      r_idx <= '0;
      r_wdata <= '0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out <= '0;
      r_dq_oe <= 1'b0;
      r_we_n <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_state <= LOW;
          r_cnt <= '0;
          r_wr <= wr_en;
          r_idx <= w_idx;
          r_wdata <= write_data;
          r_sram_addr <= {w_idx, 1'b0};
          r_dq_out <= write_data[15:0];
          r_dq_oe <= wr_en;
          r_we_n <= !wr_en;
        end
        LOW: if (w_last) begin
          r_state <= HIGH;
          r_cnt <= '0;
          r_sram_addr <= {r_idx, 1'b1};
          r_dq_out <= r_wdata[31:16];
          if (!r_wr) r_read_data[15:0] <= sram_dq_in;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
        HIGH: if (w_last) begin
          r_state <= DONE;
          r_cnt <= '0;
          r_dq_oe <= 1'b0;
          r_we_n <= 1'b1;
          if (!r_wr) r_read_data[31:16] <= sram_dq_in;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: vector table, corner sequences and random traffic against a word-level memory model
module tb_sram_ctrl;
  localparam int W = 2;
  localparam int BUSY = 1 + 2 * W;
`ifdef SRAM_LAST_READ_EN
  localparam bit LR = 1'b1;
`else
  localparam bit LR = 1'b0;
`endif

  typedef struct {
    bit rd;
    bit wr;
    bit [31:0] a;
    bit [31:0] wd;
    bit [31:0] e_rd;
    int e_busy;
    bit [17:0] e_lo;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_en = 1'b0;
  logic wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic sram_dq_oe;
  logic sram_we_n;

  bit [15:0] sram_mem [0:262143];
  bit [31:0] ref_mem [0:131071];
  bit lr_valid = 1'b0;
  bit [16:0] lr_idx = '0;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl [11];

  sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  assign sram_dq_in = sram_mem[sram_addr];
  always @(posedge clk) if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1) sram_mem[sram_addr] <= sram_dq_out;

  function automatic bit [16:0] widx(input bit [31:0] a);
    bit [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_update(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] wd);
    if (wr) begin
      ref_mem[widx(a)] = wd;
      lr_valid = 1'b0;
    end else if (rd) begin
      lr_valid = 1'b1;
      lr_idx = widx(a);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic apply(input string nm, input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] wd,
                       input bit [31:0] e_rd, input int e_busy, input bit [17:0] e_lo);
    logic [17:0] prev, a_lo, a_hi;
    logic [31:0] rdat;
    int busy, we_lo, k;
    bit stable;
    bit [16:0] ix;
    prev = sram_addr;
    busy = 0;
    we_lo = 0;
    stable = 1'b1;
    a_lo = '0;
    a_hi = '0;
    rd_en = rd;
    wr_en = wr;
    address = a;
    write_data = wd;
    #1;
    while (ready !== 1'b1 && busy < 64) begin
      busy++;
      @(posedge clk);
      #1;
      k = busy - 1;
      if (sram_we_n !== 1'b1) we_lo++;
      if (k == 0) a_lo = sram_addr;
      if (k == W) a_hi = sram_addr;
      if (k < W && sram_addr !== a_lo) stable = 1'b0;
      if (k >= W && k < 2 * W && sram_addr !== a_hi) stable = 1'b0;
    end
    rdat = read_data;
    rd_en = 1'b0;
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_busy"}, busy, e_busy);
    if (e_busy > 0) begin
      chk({nm, "_addr_lo"}, 32'(a_lo), 32'(e_lo));
      chk({nm, "_addr_hi"}, 32'(a_hi), 32'(e_lo | 18'd1));
      chk({nm, "_addr_stable"}, 32'(stable), 32'd1);
      chk({nm, "_we_low"}, we_lo, wr ? 2 * W : 0);
    end else begin
      chk({nm, "_hit_addr"}, 32'(sram_addr), 32'(prev));
    end
    if (rd && !wr) chk({nm, "_rdata"}, rdat, e_rd);
    if (wr) begin
      ix = widx(a);
      chk({nm, "_mem"}, {sram_mem[{ix, 1'b1}], sram_mem[{ix, 1'b0}]}, wd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit rd, wr;
    bit [31:0] a, wd, last_rd_a;
    bit [16:0] ix;
    bit hit;
    #2 rst = 1'b0;
    #1;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("rst_dq_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_ready", 32'(ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;

    tbl[0]  = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 32'h0, BUSY, 18'd2};
    tbl[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0, 32'hDEADBEEF, BUSY, 18'd2};
    tbl[2]  = '{1'b1, 1'b1, 32'd1024, 32'h12345678, 32'h0, BUSY, 18'd0};
    tbl[3]  = '{1'b1, 1'b0, 32'd1024 + 32'h80000, 32'h0, 32'h12345678, BUSY, 18'd0};
    tbl[4]  = '{1'b0, 1'b1, 32'd1032, 32'hCAFEF00D, 32'h0, BUSY, 18'd4};
    tbl[5]  = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hCAFEF00D, BUSY, 18'd4};
    tbl[6]  = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'hCAFEF00D, LR ? 0 : BUSY, 18'd4};
    tbl[7]  = '{1'b0, 1'b1, 32'd1032, 32'h0BADC0DE, 32'h0, BUSY, 18'd4};
    tbl[8]  = '{1'b1, 1'b0, 32'd1032, 32'h0, 32'h0BADC0DE, BUSY, 18'd4};
    tbl[9]  = '{1'b0, 1'b1, 32'd1020, 32'h55AA33CC, 32'h0, BUSY, 18'h3FFFE};
    tbl[10] = '{1'b1, 1'b0, 32'd1020, 32'h0, 32'h55AA33CC, BUSY, 18'h3FFFE};
    for (int i = 0; i < 11; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].e_rd, tbl[i].e_busy, tbl[i].e_lo);
      model_update(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd);
    end

    rd_en = 1'b1;
    address = 32'd1028;
    #1 chk("drop_issue_ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b1;
    address = 32'd1040;
    write_data = 32'hA5A55A5A;
    #1 chk("drop_ready_low", 32'(ready), 32'h0);
    wait_ready(n);
    chk("drop_rd_cycles", 1 + n, BUSY);
    chk("drop_rd_data", read_data, ref_mem[widx(32'd1028)]);
    @(posedge clk);
    #1;
    chk("pend_wr_idle_ready", 32'(ready), 32'h0);
    chk("pend_wr_idle_we_n", 32'(sram_we_n), 32'h1);
    wait_ready(n);
    chk("pend_wr_cycles", n, BUSY);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    chk("pend_wr_mem", {sram_mem[{widx(32'd1040), 1'b1}], sram_mem[{widx(32'd1040), 1'b0}]}, 32'hA5A55A5A);
    model_update(1'b1, 1'b0, 32'd1028, 32'h0);
    model_update(1'b0, 1'b1, 32'd1040, 32'hA5A55A5A);

    rd_en = 1'b1;
    address = 32'd1028;
    repeat (1 + W) @(posedge clk);
    #1;
    chk("mid_rst_pre_addr", 32'(sram_addr), 32'd3);
    chk("mid_rst_pre_ready", 32'(ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("mid_rst_read_data", read_data, 32'h0);
    chk("mid_rst_addr", 32'(sram_addr), 32'h0);
    chk("mid_rst_dq_out", 32'(sram_dq_out), 32'h0);
    chk("mid_rst_oe", 32'(sram_dq_oe), 32'h0);
    chk("mid_rst_we_n", 32'(sram_we_n), 32'h1);
    chk("mid_rst_ready_req", 32'(ready), 32'h0);
    rd_en = 1'b0;
    #1 chk("mid_rst_ready_idle", 32'(ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    lr_valid = 1'b0;
    apply("post_rst_rd", 1'b1, 1'b0, 32'd1028, 32'h0, ref_mem[widx(32'd1028)], BUSY, 18'd2);
    model_update(1'b1, 1'b0, 32'd1028, 32'h0);

    last_rd_a = 32'd1028;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin rd = 1'b1; wr = 1'b0; end
        1: begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      a = 32'd1024 + 32'($urandom_range(0, 15)) * 4 + (32'($urandom_range(0, 3)) << 19);
      if (rd && !wr && $urandom_range(0, 2) == 0) a = last_rd_a;
      wd = $urandom;
      ix = widx(a);
      hit = LR && rd && !wr && lr_valid && lr_idx == ix;
      apply($sformatf("rnd%0d", i), rd, wr, a, wd, ref_mem[ix], hit ? 0 : BUSY, {ix, 1'b0});
      model_update(rd, wr, a, wd);
      if (rd && !wr) last_rd_a = a;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
